// File: rtl/vector_pkg.sv
// Shared numeric types, frame defaults and scheduler state encoding for the ray pipeline.
package vector_pkg;

    localparam int FP_FRAC_BITS = 21;
    localparam int DEF_H_RES    = 640;
    localparam int DEF_V_RES    = 480;

    typedef logic signed [31:0] fp;

    typedef struct packed {
        fp x;
        fp y;
        fp z;
    } vec3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } sched_state_t;

    // Integer pixel index to Q11.21.
    function automatic fp int_to_fp(input logic [31:0] v);
        return fp'(v << FP_FRAC_BITS);
    endfunction

endpackage

// File: rtl/ray_pixel_scheduler_if.sv
// Host/generator-facing bundle of the pixel scheduler: master = host side, slave = scheduler.
interface ray_pixel_scheduler_if;
    import vector_pkg::*;

    logic        frame_start;
    logic        frame_abort;
    vec3         cam_forward_in;
    vec3         cam_right_in;
    vec3         cam_up_in;
    logic        ray_valid;
    logic        credit_return;

    vec3         camera_forward;
    vec3         camera_right;
    vec3         camera_up;
    fp           screen_x;
    fp           screen_y;
    logic        pix_valid;
    logic        busy;
    logic        frame_done;
    logic        credit_err;
    logic [31:0] stall_cycles;

    modport master (
        output frame_start, frame_abort, cam_forward_in, cam_right_in, cam_up_in,
               ray_valid, credit_return,
        input  camera_forward, camera_right, camera_up, screen_x, screen_y,
               pix_valid, busy, frame_done, credit_err, stall_cycles
    );

    modport slave (
        input  frame_start, frame_abort, cam_forward_in, cam_right_in, cam_up_in,
               ray_valid, credit_return,
        output camera_forward, camera_right, camera_up, screen_x, screen_y,
               pix_valid, busy, frame_done, credit_err, stall_cycles
    );

endinterface

// File: rtl/ray_pixel_scheduler_credit_counter.sv
// Saturating up/down counter; an out-of-range step holds the value and raises o_err for that cycle.
module credit_counter #(
    parameter int MAX_COUNT  = 16,
    parameter int INIT_COUNT = 0,
    parameter int W          = $clog2(MAX_COUNT + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_err
);

    logic [W-1:0] r_count;
    logic [W-1:0] w_next;
    logic         w_err;

    // Next count: simultaneous inc/dec cancel out.
    always_comb begin
        w_next = r_count;
        w_err  = 1'b0;
        if (i_inc && !i_dec) begin
            if (r_count == W'(MAX_COUNT)) begin
                w_err = 1'b1;
            end else begin
                w_next = r_count + W'(1);
            end
        end else if (i_dec && !i_inc) begin
            if (r_count == W'(0)) begin
                w_err = 1'b1;
            end else begin
                w_next = r_count - W'(1);
            end
        end else begin
            w_next = r_count;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= W'(INIT_COUNT);
        end else begin
            r_count <= w_next;
        end
    end

    assign o_count = r_count;
    assign o_err   = w_err;

endmodule

// File: rtl/ray_pixel_scheduler.sv
// Raster-order, credit-throttled pixel issuer with frozen per-frame camera basis.
// Optional stall counter enabled by defining RAY_SCHED_PERF_EN.
module ray_pixel_scheduler
    import vector_pkg::*;
#(
    parameter int H_RES   = DEF_H_RES,
    parameter int V_RES   = DEF_V_RES,
    parameter int CREDITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    ray_pixel_scheduler_if.slave bus
);

    localparam int PX_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int PY_W = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int CW   = $clog2(CREDITS + 1);

    sched_state_t    r_state;
    sched_state_t    w_next_state;
    logic [PX_W-1:0] r_px;
    logic [PY_W-1:0] r_py;
    logic [CW-1:0]   w_credits;
    logic [CW-1:0]   w_inflight;
    logic            w_credits_err;
    logic            w_inflight_err;
    logic            w_issue;
    logic            w_last_px;
    logic            w_last_pix;

    fp               r_screen_x;
    fp               r_screen_y;
    vec3             r_cam_forward;
    vec3             r_cam_right;
    vec3             r_cam_up;
    logic            r_pix_valid;
    logic            r_busy;
    logic            r_frame_done;
    logic            r_credit_err;

    // A same-cycle credit return lets RUN issue even at zero credits.
    assign w_issue    = (r_state == S_RUN) && !bus.frame_abort &&
                        ((w_credits != CW'(0)) || bus.credit_return);
    assign w_last_px  = (r_px == PX_W'(H_RES - 1));
    assign w_last_pix = w_last_px && (r_py == PY_W'(V_RES - 1));

    credit_counter #(
        .MAX_COUNT (CREDITS),
        .INIT_COUNT(CREDITS),
        .W         (CW)
    ) u_credits (
        .clk    (clk),
        .rst    (rst),
        .i_inc  (bus.credit_return),
        .i_dec  (w_issue),
        .o_count(w_credits),
        .o_err  (w_credits_err)
    );

    credit_counter #(
        .MAX_COUNT (CREDITS),
        .INIT_COUNT(0),
        .W         (CW)
    ) u_inflight (
        .clk    (clk),
        .rst    (rst),
        .i_inc  (w_issue),
        .i_dec  (bus.ray_valid),
        .o_count(w_inflight),
        .o_err  (w_inflight_err)
    );

    // Frame sequencing next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.frame_start) w_next_state = S_LATCH;
                else                 w_next_state = S_IDLE;
            end
            S_LATCH: w_next_state = S_RUN;
            S_RUN: begin
                if (bus.frame_abort || (w_issue && w_last_pix)) w_next_state = S_DRAIN;
                else                                             w_next_state = S_RUN;
            end
            S_DRAIN: begin
                if (w_inflight == CW'(0)) w_next_state = S_DONE;
                else                      w_next_state = S_DRAIN;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Registered strobes and sticky error, all derived from the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_credit_err <= 1'b0;
        end else begin
            r_pix_valid  <= w_issue;
            r_busy       <= (w_next_state != S_IDLE);
            r_frame_done <= (w_next_state == S_DONE);
            r_credit_err <= r_credit_err | w_credits_err | w_inflight_err;
        end
    end

    // Camera capture and raster walk; coordinates register alongside pix_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cam_forward <= '0;
            r_cam_right   <= '0;
            r_cam_up      <= '0;
            r_px          <= PX_W'(0);
            r_py          <= PY_W'(0);
            r_screen_x    <= 32'sd0;
            r_screen_y    <= 32'sd0;
        end else if (r_state == S_LATCH) begin
            r_cam_forward <= bus.cam_forward_in;
            r_cam_right   <= bus.cam_right_in;
            r_cam_up      <= bus.cam_up_in;
            r_px          <= PX_W'(0);
            r_py          <= PY_W'(0);
        end else if (w_issue) begin
            r_screen_x <= int_to_fp(32'(r_px));
            r_screen_y <= int_to_fp(32'(r_py));
            if (w_last_px) begin
                r_px <= PX_W'(0);
                r_py <= r_py + PY_W'(1);
            end else begin
                r_px <= r_px + PX_W'(1);
            end
        end
    end

`ifdef RAY_SCHED_PERF_EN
    logic [31:0] r_stall_cycles;

    // Cycles in RUN lost to an empty credit pool, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= 32'd0;
        end else if (r_state == S_LATCH) begin
            r_stall_cycles <= 32'd0;
        end else if ((r_state == S_RUN) && !bus.frame_abort && (w_credits == CW'(0)) &&
                     !bus.credit_return && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
`else
    assign bus.stall_cycles = 32'd0;
`endif

    assign bus.camera_forward = r_cam_forward;
    assign bus.camera_right   = r_cam_right;
    assign bus.camera_up      = r_cam_up;
    assign bus.screen_x       = r_screen_x;
    assign bus.screen_y       = r_screen_y;
    assign bus.pix_valid      = r_pix_valid;
    assign bus.busy           = r_busy;
    assign bus.frame_done     = r_frame_done;
    assign bus.credit_err     = r_credit_err;

endmodule

// File: doc/ray_pixel_scheduler.md
# ray_pixel_scheduler

Frame-level controller that drives the ray generator pipeline. It sweeps pixel coordinates in raster order and issues them as Q11.21 `screen_x`/`screen_y` with a one-cycle valid. Issue is throttled by a credit counter that mirrors downstream buffer space. The block freezes the camera basis for the whole frame and reports frame completion once every issued ray has been accounted for.

## Interface
Parameters:
- `H_RES`, default 640: pixels per line.
- `V_RES`, default 480: lines per frame.
- `CREDITS`, default 16: downstream buffer depth, which is the maximum number of rays in flight.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `frame_start`  in  1  pulse; begins a frame when idle.
- `frame_abort`  in  1  pulse; stops further issue and drains.
- `cam_forward_in`, `cam_right_in`, `cam_up_in`  in  vec3  camera basis, sampled at frame start.
- `camera_forward`, `camera_right`, `camera_up`  out  vec3  frozen basis fed to the generator.
- `screen_x`, `screen_y`  out  fp  pixel coordinate in Q11.21 (integer << 21).
- `pix_valid`  out  1  issue strobe, connected to the generator's `valid_in`.
- `ray_valid`  in  1  generator `valid_out`; one per completed ray.
- `credit_return`  in  1  downstream has freed one buffer slot.
- `busy`  out  1  high whenever state is not IDLE.
- `frame_done`  out  1  one-cycle pulse at the end of a frame or abort.
- `credit_err`  out  1  sticky; set on credit overflow or in-flight underflow.
- `stall_cycles`  out  32  present only under the macro described in Configuration.

## Operation
States: IDLE → LATCH → RUN → DRAIN → DONE → IDLE.
- IDLE: outputs quiescent. `frame_start` moves to LATCH. `frame_abort` is ignored.
- LATCH: capture the three `cam_*_in` vectors into the output registers. Clear `px`/`py`. Go to RUN.
- RUN: issue one pixel per cycle while `credits > 0`.
  - On issue: `px` increments. At `px == H_RES-1`, wrap to 0 and increment `py`.
  - The issue of pixel (H_RES-1, V_RES-1) moves to DRAIN.
  - `frame_abort` moves to DRAIN immediately; no pixel issues in the abort cycle.
- DRAIN: no issue. Wait until `inflight == 0`, then go to DONE.
- DONE: pulse `frame_done` for one cycle, then go to IDLE.
- `frame_start` outside IDLE is ignored.

Counters:
- `credits` resets to CREDITS.
  - Decrement on issue; increment on `credit_return`.
  - Both in the same cycle: unchanged.
  - A return while `credits == CREDITS`: hold at CREDITS and set `credit_err`.
- `inflight` resets to 0.
  - Increment on issue; decrement on `ray_valid`.
  - Both in the same cycle: unchanged.
  - `ray_valid` while `inflight == 0`: hold at 0 and set `credit_err`.
- Widths: `px` and `py` are clog2 of their resolution. `credits` and `inflight` are clog2(CREDITS+1).
- `credit_return` and `ray_valid` keep being counted in every state. Credits continue to return after DONE.
- Camera outputs hold their latched value until the next LATCH.

## Timing
- Reset values:
  - state IDLE.
  - `screen_x`, `screen_y`, camera outputs, `px`, `py`, `inflight`, `stall_cycles`: 0.
  - `credits`: CREDITS.
  - `pix_valid`, `busy`, `frame_done`, `credit_err`: 0.
- Reset mid-frame returns to IDLE in the same edge-free manner (asynchronous). Rays already in flight are discarded by the system.
- Cycle timing:
  - `frame_start` sampled at edge N → LATCH in cycle N+1 → first `pix_valid` registered at edge N+2.
  - `screen_x`, `screen_y` and `pix_valid` are registered together.
  - Credit decrement takes effect the edge after issue. The issue decision uses the current `credits` plus any same-cycle `credit_return`, so issue is back-to-back when a credit is returned every cycle.
- Full frame with no stalls: H_RES·V_RES issue cycles plus 2 (IDLE→RUN), plus drain time until `inflight == 0`, plus 1 for DONE.
- `busy` rises the cycle after `frame_start` and falls with the DONE→IDLE transition.

## Configuration
- `RAY_SCHED_PERF_EN` defined:
  - `stall_cycles` counts cycles in RUN where issue was blocked by `credits == 0`.
  - It clears on LATCH and saturates at 2^32-1.
- Undefined: the counter logic is removed and `stall_cycles` is tied to 0.

## Structure
- Shared package (`vector_pkg`):
  - `fp` and `vec3` typedefs.
  - `FP_FRAC_BITS = 21` for the Q11.21 shift.
  - Default `H_RES`/`V_RES` constants, shared with the ray generator so its scale constants stay consistent.
  - State enum `sched_state_t`.
- One sub-module, `credit_counter`: parameterised up/down counter with saturation and an error flag. It is instanced twice, once for credits and once for in-flight.

## Test plan
- H_RES=4, V_RES=2, CREDITS=16, `credit_return` echoes `pix_valid`:
  - 8 consecutive `pix_valid`.
  - Coordinates (0,0)…(3,0),(0,1)…(3,1); `screen_x` for px=3 is 32'h00600000.
  - `frame_done` arrives after the 8th `ray_valid`.
- CREDITS=2, no `credit_return`: exactly 2 issues, then RUN stalls. With the macro, `stall_cycles` increments each cycle. Return 1 credit → exactly 1 further issue.
- `frame_abort` after 3 issues, 3 `ray_valid` then returned → DRAIN, no 4th issue, `frame_done` once `inflight == 0`, state IDLE.
- `credit_return` pulsed while `credits == CREDITS` → `credit_err` = 1 and `credits` unchanged. `ray_valid` with `inflight == 0` → `credit_err` = 1.
- `rst` asserted mid-RUN → all outputs at reset values immediately. A new `frame_start` restarts from (0,0) with the newly latched camera vectors.
- `cam_*_in` changed during RUN → camera outputs unchanged until the next frame's LATCH.
